// File: rtl/seq_det_rate_monitor.sv
// seq_det_rate_monitor
//   Counts "101" detections (det_in pulses from the sequence detector) over
//   fixed windows of counting cycles, keeps a saturating lifetime total and
//   raises a level alarm when a completed window reaches a threshold.
//
// Ports
//   clk       in   clock, all state on posedge
//   rst       in   synchronous reset, active-high, highest priority
//   en        in   monitor enable; low returns to IDLE and drops the partial window
//   det_in    in   detector output, one-cycle pulse per detection
//   win_len   in   [WIN_W] window length in counting edges (0 = 2^WIN_W),
//                  sampled at every window start
//   thresh    in   [CNT_W] alarm threshold, 0 disables the alarm
//   clr       in   synchronous clear of counters and alarm
//   win_cnt   out  [CNT_W] detections so far in the current window
//   last_cnt  out  [CNT_W] final count of the latest completed window
//   win_done  out  one-cycle pulse after a window completes
//   alarm     out  high while the latest completed window met thresh
//   total     out  [TOT_W] lifetime detection count, saturating
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | not counting; next enabled edge starts a window
// ST_RUN   | counting; last completed window was below threshold
// ST_ALARM | counting; last completed window met threshold
module seq_det_rate_monitor #(
  parameter int WIN_W = 8,
  parameter int CNT_W = 8,
  parameter int TOT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             det_in,
  input  logic [WIN_W-1:0] win_len,
  input  logic [CNT_W-1:0] thresh,
  input  logic             clr,
  output logic [CNT_W-1:0] win_cnt,
  output logic [CNT_W-1:0] last_cnt,
  output logic             win_done,
  output logic             alarm,
  output logic [TOT_W-1:0] total
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_ALARM = 2'd2;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [TOT_W-1:0] TOT_MAX = '1;

  logic [1:0]       state_q, state_d;
  // Remaining counting edges in the window minus one; the window ends on the
  // edge where it reads zero. Loading win_len-1 makes win_len=0 wrap to
  // all-ones, which gives the 2^WIN_W window for free.
  logic [WIN_W-1:0] rem_q, rem_d;
  logic [CNT_W-1:0] win_cnt_q, win_cnt_d;
  logic [CNT_W-1:0] last_cnt_q, last_cnt_d;
  logic [TOT_W-1:0] total_q, total_d;
  logic             win_done_q, win_done_d;
  logic             alarm_q, alarm_d;

  logic [WIN_W-1:0] rem_load;
  logic [CNT_W-1:0] win_cnt_nxt;
  logic [TOT_W-1:0] total_nxt;

  assign rem_load = win_len - WIN_W'(1);

  // Window count including this edge's detection, saturating.
  assign win_cnt_nxt = (det_in && (win_cnt_q != CNT_MAX)) ? win_cnt_q + CNT_W'(1) : win_cnt_q;
  assign total_nxt   = (det_in && (total_q != TOT_MAX)) ? total_q + TOT_W'(1) : total_q;

  always_comb begin
    state_d    = state_q;
    rem_d      = rem_q;
    win_cnt_d  = win_cnt_q;
    last_cnt_d = last_cnt_q;
    total_d    = total_q;
    win_done_d = 1'b0;
    alarm_d    = alarm_q;

    if (clr) begin
      win_cnt_d  = '0;
      last_cnt_d = '0;
      total_d    = '0;
      rem_d      = '0;
      alarm_d    = 1'b0;
      if (en) begin
        state_d = ST_RUN;
        rem_d   = rem_load;
      end else begin
        state_d = ST_IDLE;
      end
    end else if (!en) begin
      state_d   = ST_IDLE;
      win_cnt_d = '0;
      rem_d     = '0;
      alarm_d   = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_d = ST_RUN;
          rem_d   = rem_load;
        end
        ST_RUN, ST_ALARM: begin
          total_d = total_nxt;
          if (rem_q == '0) begin
            last_cnt_d = win_cnt_nxt;
            win_cnt_d  = '0;
            rem_d      = rem_load;
            win_done_d = 1'b1;
            if ((thresh != '0) && (win_cnt_nxt >= thresh)) begin
              state_d = ST_ALARM;
              alarm_d = 1'b1;
            end else begin
              state_d = ST_RUN;
              alarm_d = 1'b0;
            end
          end else begin
            win_cnt_d = win_cnt_nxt;
            rem_d     = rem_q - WIN_W'(1);
          end
        end
        default: begin
          state_d   = ST_IDLE;
          win_cnt_d = '0;
          rem_d     = '0;
          alarm_d   = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      rem_q      <= '0;
      win_cnt_q  <= '0;
      last_cnt_q <= '0;
      total_q    <= '0;
      win_done_q <= 1'b0;
      alarm_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      rem_q      <= rem_d;
      win_cnt_q  <= win_cnt_d;
      last_cnt_q <= last_cnt_d;
      total_q    <= total_d;
      win_done_q <= win_done_d;
      alarm_q    <= alarm_d;
    end
  end

  assign win_cnt  = win_cnt_q;
  assign last_cnt = last_cnt_q;
  assign win_done = win_done_q;
  assign alarm    = alarm_q;
  assign total    = total_q;

endmodule
